// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default and the fetch queue entry layout for the
// instruction fetch stage.
package fetch_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 8'h00;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched words toward decode. Flush beats push, and a pop
// of the head is honoured in the same cycle as a push.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign valid   = (count != 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & valid;
  assign do_push = push & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // The upstream issue rule keeps the queue from ever overflowing.
      assert (!(do_push && !do_pop && count == 2'd2));
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the single RAM port, gives execute's data accesses
// priority over PC fetches, and queues fetched words toward decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  // Decode handshake: a word moves when ir_valid && ir_ready at a rising edge;
  // ir_valid never depends on ir_ready.
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        count;
  logic [2:0]        budget;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign pop    = ir_valid & ir_ready;
  // Slots already committed: queued words plus the read in flight, minus
  // the word decode takes this cycle.
  assign budget = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
  assign issue  = run & ~redirect & ~d_req & (budget < 3'd2);
  assign push   = pending & ~redirect;

  assign push_entry = '{data: ram_dout, pc: pending_pc};

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .valid     (ir_valid),
    .count     (count)
  );

  assign ir_data = head.data;
  assign ir_pc   = head.pc;
  assign d_rdata = ram_dout;

  always_comb begin
    ram_addr = pc;
    ram_we   = 1'b0;
    ram_din  = d_wdata;
    if (d_req) begin
      ram_addr = d_addr;
      ram_we   = d_we & rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= RESET_PC;
      d_rvalid   <= 1'b0;
    end else begin
      d_rvalid <= d_req & ~d_we;
      if (redirect) begin
        pc      <= redirect_pc;
        pending <= 1'b0;
      end else if (issue) begin
        pc         <= pc + 1'b1;
        pending    <= 1'b1;
        pending_pc <= pc;
      end else begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: RAM model, directed latency/handshake scenarios, a
// randomized phase, and a monitor scoring the instruction and load streams.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        ir_ready;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_rvalid;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic        w_valid;
  logic [15:0] w_data;
  logic [7:0]  w_pc;
  logic [15:0] w_d_rdata;
  logic        w_d_rvalid;
  logic        w_ram_we;
  logic [7:0]  w_ram_addr;
  logic [15:0] w_ram_din;
  logic [15:0] w_ram_dout;

  logic [15:0] ram [256];
  logic [15:0] model_mem [256];
  logic [15:0] exp_q [$];
  logic [7:0]  exp_pc;
  logic [7:0]  w_exp;
  logic        prev_load;
  logic        rst_seen;
  int          delivered;
  int          w_seen;
  int          total;
  int          bad;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .run(run), .redirect(redirect),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_data(ir_data),
    .ir_pc(ir_pc), .ir_ready(ir_ready), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  instr_fetch #(.RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .run(1'b1), .redirect(1'b0),
    .redirect_pc(8'h00), .ir_valid(w_valid), .ir_data(w_data),
    .ir_pc(w_pc), .ir_ready(1'b1), .d_req(1'b0), .d_we(1'b0),
    .d_addr(8'h00), .d_wdata(16'h0000), .d_rdata(w_d_rdata),
    .d_rvalid(w_d_rvalid), .ram_we(w_ram_we), .ram_addr(w_ram_addr),
    .ram_din(w_ram_din), .ram_dout(w_ram_dout)
  );

  // Clock and synchronous RAMs
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  always @(posedge clk) w_ram_dout <= 16'hA000 + {8'h00, w_ram_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: in-order PC stream model plus load response queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      rst_seen  = 1'b1;
      exp_pc    = DEF_RESET_PC;
      prev_load = 1'b0;
      exp_q.delete();
    end else begin
      if (rst_seen) begin
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        rst_seen = 1'b0;
      end
      if (ir_valid && ir_ready) begin
        check("ir_pc", {24'd0, ir_pc}, {24'd0, exp_pc});
        check("ir_data", {16'd0, ir_data}, {16'd0, model_mem[exp_pc]});
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      check("d_rvalid_timing", {31'd0, d_rvalid}, {31'd0, prev_load});
      if (d_rvalid) begin
        if (exp_q.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
        else check("d_rdata", {16'd0, d_rdata}, {16'd0, exp_q.pop_front()});
      end
      prev_load = d_req && !d_we;
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_valid && w_seen < 4) begin
      w_exp = 8'hFE + 8'(w_seen);
      check("wrap_pc", {24'd0, w_pc}, {24'd0, w_exp});
      check("wrap_data", {16'd0, w_data}, {16'd0, 16'hA000 + {8'h00, w_exp}});
      w_seen++;
    end
  end

  task automatic redirect_test(input logic [7:0] target, input logic rdy);
    redirect    = 1'b1;
    redirect_pc = target;
    ir_ready    = rdy;
    step();
    redirect = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    check("redir_r1_valid", {31'd0, ir_valid}, 32'd0);
    step();
    @(negedge clk);
    check("redir_r2_valid", {31'd0, ir_valid}, 32'd0);
    step();
    @(negedge clk);
    check("redir_r3_valid", {31'd0, ir_valid}, 32'd1);
    check("redir_r3_pc", {24'd0, ir_pc}, {24'd0, target});
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    run = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; ir_ready = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
    total = 0; bad = 0; delivered = 0; w_seen = 0;
    rst_seen = 1'b0; prev_load = 1'b0; exp_pc = DEF_RESET_PC;
    for (int i = 0; i < 256; i++) begin
      ram[i]       = 16'hA000 + 16'(i);
      model_mem[i] = 16'hA000 + 16'(i);
    end
    repeat (3) step();

    // Startup latency and throughput
    rst_n = 1'b1; run = 1'b1; ir_ready = 1'b1;
    @(negedge clk);
    check("start_c0_valid", {31'd0, ir_valid}, 32'd0);
    step(); @(negedge clk);
    check("start_c1_valid", {31'd0, ir_valid}, 32'd0);
    step(); @(negedge clk);
    check("start_c2_valid", {31'd0, ir_valid}, 32'd1);
    check("start_c2_pc", {24'd0, ir_pc}, 32'd0);
    step();
    d0 = delivered;
    repeat (8) step();
    check("throughput", 32'(delivered - d0), 32'd8);

    // Backpressure
    ir_ready = 1'b0;
    d0 = delivered;
    repeat (5) step();
    @(negedge clk);
    check("stall_valid", {31'd0, ir_valid}, 32'd1);
    check("stall_head_pc", {24'd0, ir_pc}, {24'd0, exp_pc});
    check("stall_no_delivery", 32'(delivered - d0), 32'd0);
    step();
    ir_ready = 1'b1;
    d0 = delivered;
    repeat (6) step();
    check("release_tput", 32'(delivered - d0), 32'd6);

    // Redirects with stalled and with handshaking decode
    redirect_test(8'h40, 1'b0);
    step(); repeat (4) step();
    redirect_test(8'h20, 1'b1);
    step(); repeat (3) step();

    // Store then load, each costing one fetch slot
    d0 = delivered;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 16'h0055;
    model_mem[8'h80] = 16'h0055;
    step();
    d_we = 1'b0;
    exp_q.push_back(model_mem[8'h80]);
    step();
    d_req = 1'b0;
    repeat (6) step();
    check("dreq_slots", 32'(delivered - d0), 32'd6);

    // Reset mid-stream with a read in flight
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();

    // Randomized traffic; fetches stay below 8'h80, data lives at 8'h80+
    for (int c = 0; c < 300; c++) begin
      run         = ($urandom_range(0, 7) != 0);
      ir_ready    = ($urandom_range(0, 3) != 0);
      redirect    = (c % 32 == 0) || ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom_range(0, 63));
      d_req       = ($urandom_range(0, 3) == 0);
      d_we        = 1'($urandom_range(0, 1));
      d_addr      = 8'h80 + 8'($urandom_range(0, 63));
      d_wdata     = 16'($urandom);
      if (d_req) begin
        if (d_we) model_mem[d_addr] = d_wdata;
        else exp_q.push_back(model_mem[d_addr]);
      end
      step();
    end

    // Drain with fetching disabled
    run = 1'b0; redirect = 1'b0; d_req = 1'b0; ir_ready = 1'b1;
    begin
      int waited;
      waited = 0;
      while (waited < 10) begin
        step();
        @(negedge clk);
        if (!ir_valid) break;
        waited++;
      end
      check("drain_done", {31'd0, ir_valid}, 32'd0);
    end
    check("loads_answered", 32'(exp_q.size()), 32'd0);
    check("wrap_seen", 32'(w_seen), 32'd4);
    check("wrap_quiet", {15'd0, w_d_rvalid, w_ram_we, w_ram_din}, 32'd0);
    check("wrap_rdata_pass", {16'd0, w_d_rdata}, {16'd0, w_ram_dout});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
